// File: rtl/coffee_defs.sv
// Shared drink codes, sequencer state encodings and brew recipes.
// The drink-selection stage imports the same package.
package coffee_defs;

    localparam logic [2:0] CODE_NONE       = 3'b000;
    localparam logic [2:0] CODE_ESPRESSO   = 3'b001;
    localparam logic [2:0] CODE_CAPPUCCINO = 3'b010;
    localparam logic [2:0] CODE_LATTE      = 3'b011;
    localparam logic [2:0] CODE_MOCHA      = 3'b100;

    // The phase states are consecutive so that "later phase" is a simple ordering.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WATER  = 3'd1,
        ST_COFFEE = 3'd2,
        ST_MILK   = 3'd3,
        ST_CHOC   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ABORT  = 3'd6
    } brew_state_t;

    localparam logic [3:0] ESP_WATER  = 4'd2;
    localparam logic [3:0] ESP_COFFEE = 4'd3;
    localparam logic [3:0] ESP_MILK   = 4'd0;
    localparam logic [3:0] ESP_CHOC   = 4'd0;

    localparam logic [3:0] CAP_WATER  = 4'd2;
    localparam logic [3:0] CAP_COFFEE = 4'd2;
    localparam logic [3:0] CAP_MILK   = 4'd3;
    localparam logic [3:0] CAP_CHOC   = 4'd0;

    localparam logic [3:0] LAT_WATER  = 4'd2;
    localparam logic [3:0] LAT_COFFEE = 4'd1;
    localparam logic [3:0] LAT_MILK   = 4'd5;
    localparam logic [3:0] LAT_CHOC   = 4'd0;

    localparam logic [3:0] MOC_WATER  = 4'd2;
    localparam logic [3:0] MOC_COFFEE = 4'd2;
    localparam logic [3:0] MOC_MILK   = 4'd2;
    localparam logic [3:0] MOC_CHOC   = 4'd3;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == CODE_ESPRESSO) || (code == CODE_CAPPUCCINO) ||
               (code == CODE_LATTE) || (code == CODE_MOCHA);
    endfunction

    function automatic logic [3:0] recipe_units(input logic [2:0] code, input brew_state_t phase);
        logic [3:0] w, c, m, h, result;
        w = 4'd0;
        c = 4'd0;
        m = 4'd0;
        h = 4'd0;
        case (code)
            CODE_ESPRESSO:   begin w = ESP_WATER; c = ESP_COFFEE; m = ESP_MILK; h = ESP_CHOC; end
            CODE_CAPPUCCINO: begin w = CAP_WATER; c = CAP_COFFEE; m = CAP_MILK; h = CAP_CHOC; end
            CODE_LATTE:      begin w = LAT_WATER; c = LAT_COFFEE; m = LAT_MILK; h = LAT_CHOC; end
            CODE_MOCHA:      begin w = MOC_WATER; c = MOC_COFFEE; m = MOC_MILK; h = MOC_CHOC; end
            default:         ;
        endcase
        case (phase)
            ST_WATER:  result = w;
            ST_COFFEE: result = c;
            ST_MILK:   result = m;
            ST_CHOC:   result = h;
            default:   result = 4'd0;
        endcase
        return result;
    endfunction

    // First phase after 'from' that has a nonzero duration; DONE when none remain.
    function automatic brew_state_t next_phase(input logic [2:0] code, input brew_state_t from);
        brew_state_t result;
        result = ST_DONE;
        if (from < ST_CHOC && recipe_units(code, ST_CHOC) != 4'd0)
            result = ST_CHOC;
        if (from < ST_MILK && recipe_units(code, ST_MILK) != 4'd0)
            result = ST_MILK;
        if (from < ST_COFFEE && recipe_units(code, ST_COFFEE) != 4'd0)
            result = ST_COFFEE;
        if (from < ST_WATER && recipe_units(code, ST_WATER) != 4'd0)
            result = ST_WATER;
        return result;
    endfunction

endpackage

// File: rtl/unit_timer.sv
// Phase timer: prescaler dividing clk into recipe time units plus a 4-bit unit down-counter.
module unit_timer #(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] units,
    output logic       expire,
    output logic       zero
);

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] presc_reg;
    logic [3:0]       count_reg;
    logic             tick;

    assign tick   = (presc_reg == PRESC_MAX);
    // Expire fires on the tick that would take the count from 1 to 0.
    assign expire = tick && (count_reg == 4'd1);
    assign zero   = (count_reg == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            count_reg <= 4'd0;
        end else if (load) begin
            presc_reg <= '0;
            count_reg <= units;
        end else if (count_reg != 4'd0) begin
            if (tick) begin
                presc_reg <= '0;
                count_reg <= count_reg - 4'd1;
            end else begin
                presc_reg <= presc_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/brew_sequencer.sv
// Brew recipe sequencer: walks water/coffee/milk/chocolate phases for the latched drink code
// and drives one registered actuator enable per ingredient plus busy/done/aborted status.
module brew_sequencer
    import coffee_defs::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] c_type,
    input  logic       start,
    input  logic       cancel,
    output logic       water_en,
    output logic       coffee_en,
    output logic       milk_en,
    output logic       choc_en,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    brew_state_t state_reg, state_next;
    logic [2:0]  code_reg, code_next;
    logic        req_reg;
    logic [2:0]  code_in_reg;

    logic        timer_load;
    logic [3:0]  timer_units;
    logic        timer_expire;
    logic        timer_zero;

    logic [3:0]  phase_on_next;
    logic [3:0]  en_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        aborted_reg;

    // A valid start request is captured together with its drink code; the FSM acts one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg     <= 1'b0;
            code_in_reg <= CODE_NONE;
        end else begin
            req_reg     <= start && !cancel && code_valid(c_type);
            code_in_reg <= c_type;
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_reg && !cancel) begin
                    code_next  = code_in_reg;
                    state_next = next_phase(code_in_reg, ST_IDLE);
                end
            end
            ST_WATER, ST_COFFEE, ST_MILK, ST_CHOC: begin
                if (cancel)
                    state_next = ST_ABORT;
                else if (timer_expire || timer_zero)
                    state_next = next_phase(code_reg, state_reg);
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ABORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign timer_load  = (state_next != state_reg) &&
                         (state_next >= ST_WATER) && (state_next <= ST_CHOC);
    assign timer_units = recipe_units(code_next, state_next);

    unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .units (timer_units),
        .expire(timer_expire),
        .zero  (timer_zero)
    );

    // Bit gi tracks phase state ST_WATER+gi (water, coffee, milk, chocolate).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_phase
            assign phase_on_next[gi] = (state_next == brew_state_t'(3'(gi + 1)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            code_reg    <= CODE_NONE;
            en_reg      <= 4'b0000;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            en_reg      <= phase_on_next;
            busy_reg    <= |phase_on_next;
            done_reg    <= (state_next == ST_DONE);
            aborted_reg <= (state_next == ST_ABORT);
        end
    end

    assign water_en  = en_reg[0];
    assign coffee_en = en_reg[1];
    assign milk_en   = en_reg[2];
    assign choc_en   = en_reg[3];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer with UNIT_CYCLES=4; one line per checked cycle on failure.
module tb_brew_sequencer;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] c_type = 3'b000;
    logic       water_en, coffee_en, milk_en, choc_en, busy, done, aborted;
    logic [6:0] obs;
    logic [6:0] e;

    int pass_cnt = 0;
    int total_cnt = 0;

    brew_sequencer #(.UNIT_CYCLES(U), .CNT_W(26)) dut (
        .clk      (clk),
        .rst      (rst),
        .c_type   (c_type),
        .start    (start),
        .cancel   (cancel),
        .water_en (water_en),
        .coffee_en(coffee_en),
        .milk_en  (milk_en),
        .choc_en  (choc_en),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    assign obs = {water_en, coffee_en, milk_en, choc_en, busy, done, aborted};

    // Expected {water,coffee,milk,choc,busy,done,aborted} in cycle k+n of a brew started at edge k.
    function automatic logic [6:0] exp_vec(input int n, input int w, input int c, input int m, input int h);
        int e1, e2, e3, e4;
        logic [6:0] v;
        e1 = w * U;
        e2 = e1 + c * U;
        e3 = e2 + m * U;
        e4 = e3 + h * U;
        v = 7'b0;
        v[6] = (n >= 1) && (n <= e1);
        v[5] = (n > e1) && (n <= e2);
        v[4] = (n > e2) && (n <= e3);
        v[3] = (n > e3) && (n <= e4);
        v[2] = (n >= 1) && (n <= e4);
        v[1] = (n == e4 + 1);
        return v;
    endfunction

    // Present start for exactly one sampling edge; returns in cycle k (still idle).
    task automatic pulse_start(input logic [2:0] code);
        c_type = code;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (obs !== 7'b0) $display("FAIL reset_held got=%b exp=%b", obs, 7'b0);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs !== 7'b0) $display("FAIL reset_release got=%b exp=%b", obs, 7'b0);
        else pass_cnt++;
    endtask

    task automatic test_espresso();
        pulse_start(3'b001);
        for (int n = 0; n <= 23; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_vec(n, 2, 3, 0, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL espresso n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_mocha();
        pulse_start(3'b100);
        for (int n = 0; n <= 39; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_vec(n, 2, 2, 2, 3);
            total_cnt++;
            if (obs !== e) $display("FAIL mocha n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_invalid();
        logic [2:0] codes [3];
        codes[0] = 3'b000;
        codes[1] = 3'b110;
        codes[2] = 3'b001;
        for (int t = 0; t < 3; t++) begin
            // The last entry is a valid code with cancel held alongside start.
            cancel = (t == 2);
            pulse_start(codes[t]);
            for (int n = 0; n < 12; n++) begin
                if (n > 0) @(negedge clk);
                if (n == 2) cancel = 1'b0;
                total_cnt++;
                if (obs !== 7'b0) $display("FAIL invalid code=%b n=%0d got=%b exp=%b", codes[t], n, obs, 7'b0);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_cancel();
        pulse_start(3'b011);
        for (int n = 0; n <= 15; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_vec(n, 2, 1, 5, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL cancel_brew n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        total_cnt++;
        if (obs !== 7'b0000001) $display("FAIL cancel_abort got=%b exp=%b", obs, 7'b0000001);
        else pass_cnt++;
        for (int n = 17; n <= 19; n++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== 7'b0) $display("FAIL cancel_idle n=%0d got=%b exp=%b", n, obs, 7'b0);
            else pass_cnt++;
        end
        pulse_start(3'b001);
        for (int n = 0; n <= 22; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_vec(n, 2, 3, 0, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL cancel_restart n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        c_type = 3'b010;
        start  = 1'b1;
        @(negedge clk);
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 5) c_type = 3'b001;
            e = exp_vec(n, 2, 2, 3, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL b2b_first n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
        // The held start is re-sampled in the single idle cycle, this time with the espresso code.
        for (int n = 1; n <= 23; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            e = exp_vec(n, 2, 3, 0, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL b2b_second n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(3'b001);
        for (int n = 0; n <= 12; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_vec(n, 2, 3, 0, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL rstmid_brew n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (obs !== 7'b0) $display("FAIL rstmid_reset got=%b exp=%b", obs, 7'b0);
        else pass_cnt++;
        repeat (2) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== 7'b0) $display("FAIL rstmid_idle got=%b exp=%b", obs, 7'b0);
            else pass_cnt++;
        end
        pulse_start(3'b001);
        for (int n = 0; n <= 22; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_vec(n, 2, 3, 0, 0);
            total_cnt++;
            if (obs !== e) $display("FAIL rstmid_fresh n=%0d got=%b exp=%b", n, obs, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_espresso();
        test_mocha();
        test_invalid();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
